// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter that shares one ready-handshake memory port between two masters.
// Defining ARB_TIMEOUT_EN adds a watchdog that terminates transfers the slave never acknowledges.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 30,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  m0_read,
    input  logic [3:0]            m0_write,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [31:0]           m0_data_in,
    output logic [31:0]           m0_data_out,
    output logic                  m0_ready,
    input  logic                  m1_read,
    input  logic [3:0]            m1_write,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [31:0]           m1_data_in,
    output logic [31:0]           m1_data_out,
    output logic                  m1_ready,
    output logic                  s_read,
    output logic [3:0]            s_write,
    output logic [ADDR_WIDTH-1:0] s_address,
    output logic [31:0]           s_data_out,
    input  logic [31:0]           s_data_in,
    input  logic                  s_ready,
    output logic [1:0]            grant,
    output logic                  timeout
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT_CYCLES must be in 2..65535");
    end

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t state;
    logic   last;
    logic   req0, req1;
    logic   owner_req;
    logic   expire;

    assign req0 = m0_read | (|m0_write);
    assign req1 = m1_read | (|m1_write);
    assign owner_req = (state == GRANT0) ? req0 :
                       (state == GRANT1) ? req1 : 1'b0;

`ifdef ARB_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // Count is zero on the first grant cycle since every grant is entered from IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // A master that already gave up is aborted, not handed a spurious ready.
    assign expire = owner_req && !s_ready && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign expire = 1'b0;
`endif

    assign timeout = expire;

    always_comb begin
        s_read      = 1'b0;
        s_write     = 4'b0000;
        s_address   = '0;
        s_data_out  = '0;
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        m0_data_out = '0;
        m1_data_out = '0;
        case (state)
            GRANT0: begin
                s_read      = m0_read & ~expire;
                s_write     = expire ? 4'b0000 : m0_write;
                s_address   = m0_address;
                s_data_out  = m0_data_in;
                m0_ready    = s_ready | expire;
                m0_data_out = expire ? 32'h0 : s_data_in;
            end
            GRANT1: begin
                s_read      = m1_read & ~expire;
                s_write     = expire ? 4'b0000 : m1_write;
                s_address   = m1_address;
                s_data_out  = m1_data_in;
                m1_ready    = s_ready | expire;
                m1_data_out = expire ? 32'h0 : s_data_in;
            end
            default: ;
        endcase
    end

    // Every transfer returns through IDLE so a request held over its ready is not issued twice.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
            grant <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 && (!req1 || last)) begin
                        state <= GRANT0;
                        grant <= 2'b01;
                    end else if (req1) begin
                        state <= GRANT1;
                        grant <= 2'b10;
                    end
                end
                GRANT0: begin
                    if (s_ready || expire) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        last  <= 1'b0;
                    end else if (!req0) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end
                end
                GRANT1: begin
                    if (s_ready || expire) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        last  <= 1'b1;
                    end else if (!req1) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master arbiter sharing one ready-handshake memory port (e.g. a BRAM port or the MMIO data bus) between the CPU data port (master 0) and a second bus master such as a bootloader or DMA engine (master 1). Requests are granted one at a time with round-robin fairness. Each transfer is forwarded unchanged to the shared slave, and the slave's ready/data is returned only to the granted master. An optional watchdog terminates transfers whose slave never acknowledges.

## Interface
Parameters:
- ADDR_WIDTH, 30, word-address width for masters and slave
- TIMEOUT_CYCLES, 255, grant cycles without `s_ready` before forced termination (only used with ARB_TIMEOUT_EN); legal range 2..65535

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE state
- m0_read / m1_read  in  1  read request; held until the master's ready
- m0_write / m1_write  in  4  byte write enables; held until the master's ready
- m0_address / m1_address  in  ADDR_WIDTH  word address
- m0_data_in / m1_data_in  in  32  write data from the master
- m0_data_out / m1_data_out  out  32  read data to the master
- m0_ready / m1_ready  out  1  transfer complete, one-cycle pulse
- s_read  out  1  read strobe to the slave
- s_write  out  4  byte write enables to the slave
- s_address  out  ADDR_WIDTH  address to the slave
- s_data_out  out  32  write data to the slave
- s_data_in  in  32  read data from the slave
- s_ready  in  1  slave acknowledge
- grant  out  2  one-hot current grant ({m1,m0}); 2'b00 in IDLE
- timeout  out  1  one-cycle pulse on a watchdog-terminated transfer

## Operation
- A master is requesting when `read` is 1 or `write` is non-zero. A master may assert read and write together; both are forwarded.
- States are IDLE, GRANT0 and GRANT1. State and the round-robin pointer `last` (reset value 1, so m0 wins first) are registered.
- IDLE:
  - Only one master requesting: go to that master's GRANT state.
  - Both requesting: grant the master not equal to `last`.
  - No request: stay in IDLE.
  - Slave outputs are all zero.
- GRANTn:
  - `s_*` outputs are a combinational copy of master n's request signals.
  - `mn_ready` = `s_ready`; `mn_data_out` = `s_data_in`.
  - The other master sees ready 0 and data_out 0.
- Leaving GRANTn:
  - On `s_ready` = 1, set `last` = n and go to IDLE.
  - If master n drops its request before `s_ready`, abort: go to IDLE, issue no ready, leave `last` unchanged.
- The mandatory IDLE cycle after each transfer prevents a held request from being issued twice. Masters must deassert the request in the cycle after their ready.
- Ready raised by the slave while in IDLE is ignored.

## Timing
- Reset values: state IDLE, `last` = 1, grant 0, all `s_*` outputs 0, both m*_ready 0, both m*_data_out 0, timeout 0. Reset mid-transfer drops the grant immediately (asynchronously); no ready is issued.
- Latency: request first seen in IDLE at cycle 0; grant and slave strobe at cycle 1.
  - With a zero-wait slave (`s_ready` in cycle 1), master ready is in cycle 1.
  - Back-to-back transfers from one master: one every 2 cycles minimum.
- Simultaneous requests alternate strictly: m0, m1, m0, …
- `grant` changes only on a clock edge. `s_*` and m*_ready are combinational from the registered state and the inputs, with no other combinational paths.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to GRANTn and increments each GRANT cycle.
  - In the GRANT cycle where the count equals TIMEOUT_CYCLES−1 and `s_ready` = 0, the arbiter forces termination. In that cycle: mn_ready = 1, mn_data_out = 0, timeout = 1, `s_read`/`s_write` forced to 0, `last` = n, next state IDLE.
  - `s_ready` arriving in the same cycle wins: normal completion, no timeout.
- ARB_TIMEOUT_EN undefined: no counter; `timeout` tied to 0; a grant lasts until `s_ready` or an abort.

## Test plan
- Reset: assert reset with both masters requesting → grant = 00, s_read = 0, s_write = 0, m0_ready = m1_ready = 0. Release → grant = 01 at the next edge.
- Single read, zero-wait: m0_read, address 0x100, slave returns 0xDEADBEEF with s_ready in the same cycle → m0_ready pulse in cycle 1 with m0_data_out = 0xDEADBEEF; the next cycle is IDLE.
- Contention: both masters hold 4 writes each (s_write = F, slave 2-cycle wait) → grant order 01,10,01,10…; s_data_out matches the owning master every time; 8 transfers total.
- Abort: m1_read granted, slave silent, m1 drops its request after 3 cycles → IDLE, no m1_ready. The next contention grants m1 (`last` unchanged).
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 4): m0_write to a silent slave → in the 4th grant cycle m0_ready = 1, timeout = 1, s_write = 0. Without the macro: grant is still held after 100 cycles and timeout stays 0.
- Ready/timeout race (ARB_TIMEOUT_EN): s_ready arrives exactly in the terminal count cycle → normal completion with slave data, timeout = 0.
